i2c_master_scheduler: RTL and testbench
=======================================

Name: i2c_master_scheduler

Overview:
Round-robin scheduler that shares the single I2C master between NUM_REQ requesters, each issuing one-byte read or write transactions to a 7-bit slave address. It captures the winning request, runs the master's enable/ack/ready handshake, enforces an inter-transaction idle gap, and returns read data plus error status to the requester. It sits between on-chip clients and the I2C master, in place of the sequencing a testbench would otherwise do.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
GAP_CYCLES, 16, idle clocks enforced between consecutive master transactions
TIMEOUT_CYCLES, 4096, max clocks from enable assertion to master ready before abort

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester request; held high until that requester's rsp_valid
req_rw  input  NUM_REQ  1 = read from slave, 0 = write to slave
req_addr  input  7*NUM_REQ  slave address, requester i at bits [7i+6:7i]
req_wdata  input  8*NUM_REQ  write byte, requester i at bits [8i+7:8i]
rsp_valid  output  NUM_REQ  one-cycle completion pulse to the granted requester
rsp_error  output  1  valid with rsp_valid: 1 = nack or timeout
rsp_rdata  output  8  valid with rsp_valid on reads; 0 on writes and errors
busy  output  1  high in every state except IDLE
m_address  output  7  slave address to master
m_enable  output  1  transaction enable to master
m_rw  output  1  direction to master
m_tx_data  output  8  write byte to master
m_ack  input  1  master acknowledge-phase indication
m_nack  input  1  slave did not acknowledge
m_ready  input  1  master idle/complete
m_rx_data  input  8  byte received by master

Behaviour:
- Reset (async, reset low): state IDLE; all outputs 0; rr pointer = NUM_REQ-1 (requester 0 wins first); gap and timeout counters 0.
- States: IDLE, LAUNCH, XFER, ACK_HI, STOP_WAIT, RESP, GAP.
- IDLE: if any req_valid, grant the first index after the rr pointer (circular); in the same edge latch addr/rw/wdata into m_address/m_rw/m_tx_data, set rr pointer = grant, go LAUNCH. Latched values stay stable until next grant.
- LAUNCH: wait m_ready=1, then m_enable<=1, clear timeout counter, go XFER.
- XFER: m_enable=1; m_ack=1 -> ACK_HI.
- ACK_HI: m_ack=0 (falling edge) -> m_enable<=0, go STOP_WAIT. Enable drops exactly one clock after ack is sampled low.
- STOP_WAIT: m_enable=0; m_ready=1 -> capture m_rx_data if m_rw=1, go RESP.
- m_nack=1 sampled in XFER/ACK_HI/STOP_WAIT: m_enable<=0, set error flag, go STOP_WAIT (still waits for ready). Nack has priority over m_ack in the same cycle.
- Timeout: counter runs in XFER/ACK_HI/STOP_WAIT; reaching TIMEOUT_CYCLES-1 -> m_enable<=0, error flag set, go RESP without waiting for ready.
- RESP: one cycle; rsp_valid[grant]=1, rsp_error=flag, rsp_rdata=captured byte (0 if write or error); go GAP; clear flag.
- GAP: count GAP_CYCLES clocks, then IDLE. Requests arriving during any non-IDLE state wait; no preemption.
- Requester dropping req_valid after grant: transaction still completes and rsp_valid still pulses.
- rsp_rdata/rsp_error hold their value until the next RESP.
- Reset asserted mid-transaction: immediate return to reset values, m_enable low asynchronously, no response issued.
- Counters sized clog2(max+1); no wrap possible inside a state.

Test Plan:
- Single write: req0 valid, rw=0, addr=0x50, wdata=0xFE; master ack pulse then ready -> m_enable rises once, falls one clock after ack low; rsp_valid[0] one pulse, rsp_error=0, rsp_rdata=0x00.
- Single read: req1 rw=1, addr=0x51, m_rx_data=0xCC at ready -> rsp_valid[1], rsp_rdata=0xCC, rsp_error=0.
- Contention: req0 and req1 held continuously -> grants alternate 0,1,0,1; each m_enable rise is at least GAP_CYCLES+1 clocks after the previous rsp_valid.
- Nack: addr=0x52, master raises m_nack during XFER -> m_enable low next clock, after m_ready rsp_error=1, rsp_rdata=0x00.
- Timeout: master never acks, TIMEOUT_CYCLES=64 -> m_enable drops 64 clocks after rising, rsp_error=1, then GAP, then IDLE.
- Reset mid-XFER: reset low while m_enable=1 -> m_enable=0 immediately, no rsp_valid; after release, req0 is granted first.

Source files
------------

// File: rtl/i2c_master_scheduler.sv
// Round-robin scheduler sharing one I2C master among NUM_REQ one-byte clients.
// Grants a request, runs the master handshake, enforces an idle gap and reports status.
module i2c_master_scheduler #(
    parameter int NUM_REQ        = 2,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_rw,
    input  logic [7*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic                 rsp_error,
    output logic [7:0]           rsp_rdata,
    output logic                 busy,
    output logic [6:0]           m_address,
    output logic                 m_enable,
    output logic                 m_rw,
    output logic [7:0]           m_tx_data,
    input  logic                 m_ack,
    input  logic                 m_nack,
    input  logic                 m_ready,
    input  logic [7:0]           m_rx_data
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(NUM_REQ - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LAUNCH    = 3'd1;
    localparam logic [2:0] S_XFER      = 3'd2;
    localparam logic [2:0] S_ACK_HI    = 3'd3;
    localparam logic [2:0] S_STOP_WAIT = 3'd4;
    localparam logic [2:0] S_RESP      = 3'd5;
    localparam logic [2:0] S_GAP       = 3'd6;

    logic [2:0]       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] next_grant;
    logic [IDX_W-1:0] cand;
    logic             any_req;
    logic             err_flag;
    logic [GAP_W-1:0] gap_cnt;
    logic [TO_W-1:0]  to_cnt;

    // Scan downward so the nearest requester after the pointer is the last one written.
    always_comb begin
        any_req    = 1'b0;
        next_grant = rr_ptr;
        cand       = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = IDX_W'((int'(rr_ptr) + off) % NUM_REQ);
            if (req_valid[cand]) begin
                any_req    = 1'b1;
                next_grant = cand;
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state == S_RESP) begin
            rsp_valid[grant] = 1'b1;
        end
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            rr_ptr    <= PTR_INIT;
            grant     <= '0;
            m_address <= '0;
            m_rw      <= 1'b0;
            m_tx_data <= '0;
            m_enable  <= 1'b0;
            err_flag  <= 1'b0;
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
            gap_cnt   <= '0;
            to_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        grant     <= next_grant;
                        rr_ptr    <= next_grant;
                        m_address <= req_addr[7*int'(next_grant) +: 7];
                        m_rw      <= req_rw[next_grant];
                        m_tx_data <= req_wdata[8*int'(next_grant) +: 8];
                        state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (m_ready) begin
                        m_enable <= 1'b1;
                        to_cnt   <= '0;
                        state    <= S_XFER;
                    end
                end
                S_XFER, S_ACK_HI, S_STOP_WAIT: begin
                    to_cnt <= to_cnt + 1'b1;
                    // Timeout beats everything, then nack beats ack.
                    if (to_cnt == TO_LAST) begin
                        m_enable  <= 1'b0;
                        err_flag  <= 1'b1;
                        rsp_error <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= S_RESP;
                    end else if (state == S_STOP_WAIT) begin
                        if (m_ready) begin
                            rsp_error <= err_flag | m_nack;
                            rsp_rdata <= (m_rw && !(err_flag || m_nack)) ? m_rx_data : '0;
                            state     <= S_RESP;
                        end else if (m_nack) begin
                            err_flag <= 1'b1;
                        end
                    end else if (m_nack) begin
                        m_enable <= 1'b0;
                        err_flag <= 1'b1;
                        state    <= S_STOP_WAIT;
                    end else if (state == S_XFER && m_ack) begin
                        state <= S_ACK_HI;
                    end else if (state == S_ACK_HI && !m_ack) begin
                        m_enable <= 1'b0;
                        state    <= S_STOP_WAIT;
                    end
                end
                S_RESP: begin
                    err_flag <= 1'b0;
                    gap_cnt  <= '0;
                    state    <= S_GAP;
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_master_scheduler.sv
// Directed bench for i2c_master_scheduler: the bench plays the I2C master and the two clients,
// with every expected value worked out by hand from the scheduler's intended behaviour.
module tb_i2c_master_scheduler;
    localparam int NUM_REQ        = 2;
    localparam int GAP_CYCLES     = 16;
    localparam int TIMEOUT_CYCLES = 64;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [1:0]   req_valid;
    logic [1:0]   req_rw;
    logic [13:0]  req_addr;
    logic [15:0]  req_wdata;
    logic [1:0]   rsp_valid;
    logic         rsp_error;
    logic [7:0]   rsp_rdata;
    logic         busy;
    logic [6:0]   m_address;
    logic         m_enable;
    logic         m_rw;
    logic [7:0]   m_tx_data;
    logic         m_ack;
    logic         m_nack;
    logic         m_ready;
    logic [7:0]   m_rx_data;

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int rsp_pulses = 0;
    int enable_rise_cycle = 0;
    int last_rsp_cycle = 0;

    i2c_master_scheduler #(
        .NUM_REQ(NUM_REQ),
        .GAP_CYCLES(GAP_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_rw(req_rw),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_error(rsp_error),
        .rsp_rdata(rsp_rdata),
        .busy(busy),
        .m_address(m_address),
        .m_enable(m_enable),
        .m_rw(m_rw),
        .m_tx_data(m_tx_data),
        .m_ack(m_ack),
        .m_nack(m_nack),
        .m_ready(m_ready),
        .m_rx_data(m_rx_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cycle <= cycle + 1;
        if (rsp_valid != 2'b00) rsp_pulses <= rsp_pulses + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] rw,
                                 input logic [6:0] a0, input logic [6:0] a1,
                                 input logic [7:0] w0, input logic [7:0] w1);
        req_valid = valid;
        req_rw    = rw;
        req_addr  = {a1, a0};
        req_wdata = {w1, w0};
    endtask

    task automatic waitEnable(input string tag, output bit ok);
        int n = 0;
        while (m_enable !== 1'b1 && n < 100) begin
            step(1);
            n++;
        end
        ok = (m_enable === 1'b1);
        if (!ok) checkOutput({tag, "_enable_wait"}, 32'(m_enable), 32'd1);
        enable_rise_cycle = cycle;
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            step(1);
            n++;
        end
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Plays the master for one transaction: ack pulse (or nack), then ready with rx.
    task automatic serveTxn(input string tag, input logic [1:0] exp_rsp,
                            input logic [6:0] exp_addr, input logic exp_rw,
                            input logic [7:0] exp_wdata, input logic do_nack,
                            input logic [7:0] rx, input logic exp_err,
                            input logic [7:0] exp_rdata);
        bit ok;
        waitEnable(tag, ok);
        if (!ok) return;
        checkOutput({tag, "_addr"}, 32'(m_address), 32'(exp_addr));
        checkOutput({tag, "_rw"}, 32'(m_rw), 32'(exp_rw));
        checkOutput({tag, "_tx"}, 32'(m_tx_data), 32'(exp_wdata));
        m_ready = 1'b0;
        step(1);
        if (do_nack) begin
            m_nack = 1'b1;
            step(1);
            m_nack = 1'b0;
            checkOutput({tag, "_en_after_nack"}, 32'(m_enable), 32'd0);
        end else begin
            m_ack = 1'b1;
            step(1);
            m_ack = 1'b0;
            checkOutput({tag, "_en_during_ack"}, 32'(m_enable), 32'd1);
            step(1);
            checkOutput({tag, "_en_after_ack"}, 32'(m_enable), 32'd0);
        end
        m_ready   = 1'b1;
        m_rx_data = rx;
        step(1);
        m_rx_data = 8'h00;
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(exp_rsp));
        checkOutput({tag, "_rsp_error"}, 32'(rsp_error), 32'(exp_err));
        checkOutput({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'(exp_rdata));
        last_rsp_cycle = cycle;
    endtask

    initial begin
        bit ok;
        int n;
        int prev_rsp;
        int pulses_before;
        logic [1:0] exp_rsp;

        applyStimulus(2'b00, 2'b00, 7'h00, 7'h00, 8'h00, 8'h00);
        m_ack = 1'b0;
        m_nack = 1'b0;
        m_ready = 1'b1;
        m_rx_data = 8'h00;
        step(3);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_enable", 32'(m_enable), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_address", 32'(m_address), 32'd0);
        checkOutput("reset_rdata", 32'(rsp_rdata), 32'd0);
        reset = 1'b1;
        step(1);

        // Single write from requester 0; the source address changes after grant.
        applyStimulus(2'b01, 2'b00, 7'h50, 7'h00, 8'hFE, 8'h00);
        step(1);
        checkOutput("wr_busy", 32'(busy), 32'd1);
        checkOutput("wr_launch_enable", 32'(m_enable), 32'd0);
        req_addr[6:0] = 7'h11;
        serveTxn("wr", 2'b01, 7'h50, 1'b0, 8'hFE, 1'b0, 8'hAA, 1'b0, 8'h00);
        req_valid = 2'b00;
        step(1);
        checkOutput("wr_pulse_end", 32'(rsp_valid), 32'd0);
        waitIdle("wr");

        // Nack during XFER.
        applyStimulus(2'b01, 2'b00, 7'h52, 7'h00, 8'h33, 8'h00);
        serveTxn("nack", 2'b01, 7'h52, 1'b0, 8'h33, 1'b1, 8'h99, 1'b1, 8'h00);
        req_valid = 2'b00;
        waitIdle("nack");

        // Single read from requester 1, which drops its request right after grant.
        applyStimulus(2'b10, 2'b10, 7'h00, 7'h51, 8'h00, 8'h00);
        step(1);
        req_valid = 2'b00;
        serveTxn("rd", 2'b10, 7'h51, 1'b1, 8'h00, 1'b0, 8'hCC, 1'b0, 8'hCC);
        step(1);
        checkOutput("rd_pulse_end", 32'(rsp_valid), 32'd0);
        checkOutput("rd_rdata_hold", 32'(rsp_rdata), 32'hCC);
        waitIdle("rd");

        // Contention: both held, grants alternate starting with requester 0.
        applyStimulus(2'b11, 2'b10, 7'h20, 7'h21, 8'h5A, 8'h77);
        for (int i = 0; i < 4; i++) begin
            prev_rsp = last_rsp_cycle;
            if (i % 2 == 0)
                serveTxn($sformatf("cont%0d", i), 2'b01, 7'h20, 1'b0, 8'h5A, 1'b0, 8'h3C, 1'b0, 8'h00);
            else
                serveTxn($sformatf("cont%0d", i), 2'b10, 7'h21, 1'b1, 8'h77, 1'b0, 8'h3C, 1'b0, 8'h3C);
            if (i > 0)
                checkOutput($sformatf("cont%0d_gap", i),
                            32'((enable_rise_cycle - prev_rsp >= GAP_CYCLES + 1) &&
                                (enable_rise_cycle - prev_rsp <= GAP_CYCLES + 4)), 32'd1);
        end
        req_valid = 2'b00;
        waitIdle("cont");

        // Timeout: master never acks nor becomes ready.
        applyStimulus(2'b01, 2'b00, 7'h53, 7'h00, 8'h44, 8'h00);
        waitEnable("to", ok);
        m_ready = 1'b0;
        n = 0;
        while (m_enable === 1'b1 && n < 200) begin
            step(1);
            n++;
        end
        checkOutput("to_enable_cycles", 32'(n), 32'(TIMEOUT_CYCLES));
        checkOutput("to_rsp_valid", 32'(rsp_valid), 32'b01);
        checkOutput("to_rsp_error", 32'(rsp_error), 32'd1);
        checkOutput("to_rsp_rdata", 32'(rsp_rdata), 32'd0);
        req_valid = 2'b00;
        m_ready = 1'b1;
        step(GAP_CYCLES);
        checkOutput("to_gap_busy", 32'(busy), 32'd1);
        step(1);
        checkOutput("to_gap_done", 32'(busy), 32'd0);

        // Reset mid-XFER; requester 0 was granted last, so only a reset pointer re-grants it first.
        applyStimulus(2'b01, 2'b00, 7'h54, 7'h55, 8'h12, 8'h34);
        waitEnable("rst", ok);
        step(1);
        pulses_before = rsp_pulses;
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_enable_async", 32'(m_enable), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        step(2);
        reset = 1'b1;
        req_valid = 2'b11;
        step(1);
        checkOutput("rst_no_rsp", 32'(rsp_pulses), 32'(pulses_before));
        checkOutput("rst_first_grant", 32'(m_address), 32'h54);
        exp_rsp = 2'b01;
        serveTxn("post_rst", exp_rsp, 7'h54, 1'b0, 8'h12, 1'b0, 8'h00, 1'b0, 8'h00);
        req_valid = 2'b00;
        waitIdle("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
